dm_access_unit: RTL and testbench

MEM-stage initiator for the single-port data memory. Accepts byte/halfword/word load and store requests from the pipeline through a valid/ready handshake and drives the memory's word-wide read/write port. Sub-word stores become a read-modify-write sequence. The unit never asserts read and write together, because the memory gives read priority.

---
 rtl/dm_access_pkg.sv | 40 ++++
 rtl/dm_lane_align.sv | 53 +++++
 rtl/dm_access_unit.sv | 151 +++++++++++++++
 tb/tb_dm_access_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_access_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit:
// FSM state encodings, access-size codes, lane widths and the
// alignment helpers used by the top-level request decode.
package dm_access_pkg;

   // FSM state encodings
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_RD   = 3'd1;
   localparam logic [2:0] ST_CAP  = 3'd2;
   localparam logic [2:0] ST_WR   = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   // Access sizes; code 3 behaves as a word everywhere
   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   // Lane widths
   localparam int BYTE_W = 8;
   localparam int HALF_W = 16;

   // True when the byte offset is not a multiple of the access size
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return off[0];
         default: return (off != 2'b00);
      endcase
   endfunction

   // Clears the offset bits below the access size
   function automatic logic [1:0] force_align(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SZ_BYTE: return off;
         SZ_HALF: return {off[1], 1'b0};
         default: return 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Combinational byte-lane steering for the access unit (little-endian).
// ld_result: lane of rd_word selected by offset/size, zero- or sign-extended.
// st_merged: rd_word with the low byte/half of st_data placed in its lane;
//            a word store simply passes st_data through.
module dm_lane_align
   import dm_access_pkg::*;
(
   input  logic [31:0] rd_word,
   input  logic [31:0] st_data,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        sign,
   output logic [31:0] ld_result,
   output logic [31:0] st_merged
);

   function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                                input logic [1:0] sz, input logic sgn);
      logic [BYTE_W-1:0] b;
      logic [HALF_W-1:0] h;
      logic [31:0]       r;
      b = word[{off, 3'b000} +: BYTE_W];
      h = off[1] ? word[31:16] : word[15:0];
      case (sz)
         SZ_BYTE: r = {{(32-BYTE_W){sgn & b[BYTE_W-1]}}, b};
         SZ_HALF: r = {{(32-HALF_W){sgn & h[HALF_W-1]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] old_word, input logic [31:0] new_data,
                                               input logic [1:0] off, input logic [1:0] sz);
      logic [31:0] r;
      r = old_word;
      case (sz)
         SZ_BYTE: r[{off, 3'b000} +: BYTE_W] = new_data[BYTE_W-1:0];
         SZ_HALF: begin
            if (off[1]) r[31:16] = new_data[HALF_W-1:0];
            else        r[15:0]  = new_data[HALF_W-1:0];
         end
         default: r = new_data;
      endcase
      return r;
   endfunction

   // Both lane paths are pure decode of the inputs
   always_comb begin
      ld_result = load_extract(rd_word, offset, size, sign);
      st_merged = store_merge(rd_word, st_data, offset, size);
   end

endmodule

// File: rtl/dm_access_unit.sv
// MEM-stage initiator for the single-port data memory. One request in
// flight; sub-word stores run read-modify-write. Read and write strobes
// are decoded from distinct states so they can never overlap.
// Handshake: a request is taken at the rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE. resp_valid is a
// one-cycle pulse in DONE and qualifies resp_err; resp_rdata holds the
// load result (0 for stores and errors).
// Build option: DM_ACCESS_MISALIGN_CHK_EN enables misalignment detection
// with an error response; without it the access is force-aligned.
module dm_access_unit
   import dm_access_pkg::*;
#(
   parameter int DM_ADDR_W = 16,
   parameter int DATA_W    = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [1:0]           req_size,
   input  logic                 req_sign,
   input  logic [31:0]          req_addr,
   input  logic [DATA_W-1:0]    req_wdata,
   output logic                 resp_valid,
   output logic [DATA_W-1:0]    resp_rdata,
   output logic                 resp_err,
   output logic                 DM_read,
   output logic                 DM_write,
   output logic [DM_ADDR_W-1:0] DM_addr,
   output logic [DATA_W-1:0]    DM_in,
   input  logic [DATA_W-1:0]    DM_out
);

   logic [2:0]           state_q, state_d;
   logic [DM_ADDR_W+1:0] addr_q, addr_d;
   logic [1:0]           size_q, size_d;
   logic                 sign_q, sign_d;
   logic                 we_q, we_d;
   logic [DATA_W-1:0]    wbuf_q, wbuf_d;
   logic [DATA_W-1:0]    rdata_q, rdata_d;
   logic                 err_q, err_d;

   logic                 req_mis;
   logic [1:0]           req_off;
   logic [DATA_W-1:0]    ld_result, st_merged;
   logic                 unused_addr_hi;

   assign unused_addr_hi = ^req_addr[31:DM_ADDR_W+2];

`ifdef DM_ACCESS_MISALIGN_CHK_EN
   assign req_mis = is_misaligned(req_size, req_addr[1:0]);
   assign req_off = req_addr[1:0];
`else
   assign req_mis = 1'b0;
   assign req_off = force_align(req_size, req_addr[1:0]);
`endif

   dm_lane_align u_lane_align (
      .rd_word   (DM_out),
      .st_data   (wbuf_q),
      .offset    (addr_q[1:0]),
      .size      (size_q),
      .sign      (sign_q),
      .ld_result (ld_result),
      .st_merged (st_merged)
   );

   // Next-state and datapath-register update for the access sequence
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      size_d  = size_q;
      sign_d  = sign_q;
      we_d    = we_q;
      wbuf_d  = wbuf_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               addr_d  = {req_addr[DM_ADDR_W+1:2], req_off};
               size_d  = req_size;
               sign_d  = req_sign;
               we_d    = req_we;
               wbuf_d  = req_wdata;
               rdata_d = '0;
               err_d   = req_mis;
               if (req_mis)
                  state_d = ST_DONE;
               else if (!req_we || req_size == SZ_BYTE || req_size == SZ_HALF)
                  state_d = ST_RD;
               else
                  state_d = ST_WR;
            end
         end
         ST_RD:   state_d = ST_CAP;
         ST_CAP: begin
            // DM_out is valid here: finish a load or build the RMW word
            if (we_q) begin
               wbuf_d  = st_merged;
               state_d = ST_WR;
            end else begin
               rdata_d = ld_result;
               state_d = ST_DONE;
            end
         end
         ST_WR:   state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and request registers; reset aborts any access in progress
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         size_q  <= SZ_BYTE;
         sign_q  <= 1'b0;
         we_q    <= 1'b0;
         wbuf_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         sign_q  <= sign_d;
         we_q    <= we_d;
         wbuf_q  <= wbuf_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Outputs decoded from the registered state
   always_comb begin
      req_ready  = (state_q == ST_IDLE);
      resp_valid = (state_q == ST_DONE);
      resp_err   = err_q & (state_q == ST_DONE);
      resp_rdata = rdata_q;
      DM_read    = (state_q == ST_RD);
      DM_write   = (state_q == ST_WR);
      DM_addr    = addr_q[DM_ADDR_W+1:2];
      DM_in      = (state_q == ST_WR) ? wbuf_q : '0;
   end

   a_no_rd_wr_overlap: assert property (@(posedge clk) disable iff (rst) !(DM_read && DM_write));

endmodule

// File: tb/tb_dm_access_unit.sv
// Bench for dm_access_unit with a registered-read single-port memory model.
// Directed requests push expected responses and memory strobes into queues;
// a monitor on the falling edge pops and compares them as they appear.
module tb_dm_access_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic        req_sign = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        DM_read;
   logic        DM_write;
   logic [15:0] DM_addr;
   logic [31:0] DM_in;
   logic [31:0] DM_out = '0;

   dm_access_unit #(.DM_ADDR_W(16), .DATA_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_sign   (req_sign),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .DM_read    (DM_read),
      .DM_write   (DM_write),
      .DM_addr    (DM_addr),
      .DM_in      (DM_in),
      .DM_out     (DM_out)
   );

   // clock and cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // memory model: registered read, read has priority over write
   logic [31:0] mem [0:65535];
   always @(posedge clk) begin
      if (DM_read) DM_out <= mem[DM_addr];
      else if (DM_write) mem[DM_addr] <= DM_in;
   end

   // scoreboard state
   int checks = 0;
   int errors = 0;
   logic [31:0] exp_rdata_q[$];
   logic [0:0]  exp_err_q[$];
   int          exp_resp_cyc_q[$];
   logic [15:0] exp_rd_addr_q[$];
   int          exp_rd_cyc_q[$];
   logic [15:0] exp_wr_addr_q[$];
   logic [31:0] exp_wr_data_q[$];
   int          exp_wr_cyc_q[$];
   int prev_acc = -100;
   int prev_lat = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (DM_read || DM_write)
            chk("rd_wr_exclusive", {31'b0, DM_read & DM_write}, 32'd0);
         else
            chk("dm_in_idle", DM_in, 32'd0);
         if (DM_read) begin
            if (exp_rd_addr_q.size() == 0) fail_now("unexpected_read");
            else begin
               chk("rd_addr", {16'b0, DM_addr}, {16'b0, exp_rd_addr_q.pop_front()});
               chk("rd_cycle", cyc, exp_rd_cyc_q.pop_front());
            end
         end
         if (DM_write) begin
            if (exp_wr_addr_q.size() == 0) fail_now("unexpected_write");
            else begin
               chk("wr_addr", {16'b0, DM_addr}, {16'b0, exp_wr_addr_q.pop_front()});
               chk("wr_data", DM_in, exp_wr_data_q.pop_front());
               chk("wr_cycle", cyc, exp_wr_cyc_q.pop_front());
            end
         end
         if (resp_valid) begin
            chk("ready_in_done", {31'b0, req_ready}, 32'd0);
            if (exp_rdata_q.size() == 0) fail_now("unexpected_resp");
            else begin
               chk("resp_rdata", resp_rdata, exp_rdata_q.pop_front());
               chk("resp_err", {31'b0, resp_err}, {31'b0, exp_err_q.pop_front()});
               chk("resp_cycle", cyc, exp_resp_cyc_q.pop_front());
            end
         end
      end
   end

   // driver: called on a falling edge; returns on the falling edge of cycle 1
   task automatic issue(input logic we, input logic [1:0] size, input logic sign,
                        input logic [31:0] addr, input logic [31:0] wdata, input int lat,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input logic do_rd, input logic do_wr, input int wr_ofs,
                        input logic [31:0] exp_wdata, input logic keep);
      int waits;
      int acc;
      logic [15:0] wa;
      req_valid = 1'b1;
      req_we    = we;
      req_size  = size;
      req_sign  = sign;
      req_addr  = addr;
      req_wdata = wdata;
      waits = 0;
      while (!req_ready && waits < 40) begin
         @(negedge clk);
         waits++;
      end
      if (!req_ready) begin
         fail_now("accept_timeout");
         req_valid = 1'b0;
         return;
      end
      acc = cyc;
      if (waits > 0) chk("accept_gap", acc, prev_acc + prev_lat + 1);
      wa = addr[17:2];
      exp_rdata_q.push_back(exp_rdata);
      exp_err_q.push_back(exp_err);
      exp_resp_cyc_q.push_back(acc + lat);
      if (do_rd) begin
         exp_rd_addr_q.push_back(wa);
         exp_rd_cyc_q.push_back(acc + 1);
      end
      if (do_wr) begin
         exp_wr_addr_q.push_back(wa);
         exp_wr_data_q.push_back(exp_wdata);
         exp_wr_cyc_q.push_back(acc + wr_ofs);
      end
      prev_acc = acc;
      prev_lat = lat;
      @(posedge clk);
      @(negedge clk);
      chk("ready_busy", {31'b0, req_ready}, 32'd0);
      if (!keep) req_valid = 1'b0;
      req_we    = 1'($urandom_range(0, 1));
      req_size  = 2'($urandom_range(0, 3));
      req_sign  = 1'($urandom_range(0, 1));
      req_addr  = $urandom;
      req_wdata = $urandom;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_rdata_q.size() != 0 || exp_rd_addr_q.size() != 0 ||
              exp_wr_addr_q.size() != 0 || !req_ready) && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) fail_now("drain_timeout");
      @(negedge clk);
   endtask

   initial begin
      int acc;
      int n;
      repeat (3) @(negedge clk);
      // reset values while reset is held
      chk("rst_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_err", {31'b0, resp_err}, 32'd0);
      chk("rst_dm_read", {31'b0, DM_read}, 32'd0);
      chk("rst_dm_write", {31'b0, DM_write}, 32'd0);
      chk("rst_dm_addr", {16'b0, DM_addr}, 32'd0);
      chk("rst_dm_in", DM_in, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // word store then word load
      issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1'b0, 1'b1, 1, 32'hDEADBEEF, 1'b0);
      issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0);
      wait_idle();

      // byte/half loads, three back-to-back with req_valid held high
      mem[4] = 32'h80FF7F01;
      issue(1'b0, 2'd0, 1'b1, 32'h12, 32'h0, 3, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b1);
      issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 3, 32'h00000080, 1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b1);
      issue(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 3, 32'h00000001, 1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0);
      issue(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 3, 32'hFFFF80FF, 1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0);
      issue(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 3, 32'h00007F01, 1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0);
      issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 3, 32'hFFFFFF80, 1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0);
      issue(1'b0, 2'd3, 1'b1, 32'h10, 32'h0, 3, 32'h80FF7F01, 1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0);
      wait_idle();

      // sub-word read-modify-write stores, then read back through high address bits
      mem[4] = 32'h11223344;
      issue(1'b1, 2'd1, 1'b0, 32'h12, 32'h1234AABB, 4, 32'h0, 1'b0, 1'b1, 1'b1, 3, 32'hAABB3344, 1'b0);
      issue(1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFF5A, 4, 32'h0, 1'b0, 1'b1, 1'b1, 3, 32'hAABB5A44, 1'b0);
      issue(1'b0, 2'd2, 1'b0, 32'hFFF40010, 32'h0, 3, 32'hAABB5A44, 1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0);

      // misaligned half load and misaligned word store, then check the word
`ifdef DM_ACCESS_MISALIGN_CHK_EN
      issue(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 1, 32'h0, 1'b1, 1'b0, 1'b0, 0, 32'h0, 1'b0);
      issue(1'b1, 2'd2, 1'b0, 32'h13, 32'h01020304, 1, 32'h0, 1'b1, 1'b0, 1'b0, 0, 32'h0, 1'b0);
      issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 3, 32'hAABB5A44, 1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0);
`else
      issue(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 3, 32'h00005A44, 1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0);
      issue(1'b1, 2'd2, 1'b0, 32'h13, 32'h01020304, 2, 32'h0, 1'b0, 1'b0, 1'b1, 1, 32'h01020304, 1'b0);
      issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 3, 32'h01020304, 1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0);
`endif
      wait_idle();

      // reset during CAP of a word load at 0x10
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_size  = 2'd2;
      req_sign  = 1'b0;
      req_addr  = 32'h10;
      n = 0;
      while (!req_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      acc = cyc;
      exp_rd_addr_q.push_back(16'd4);
      exp_rd_cyc_q.push_back(acc + 1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = $urandom;
      @(negedge clk);
      rst = 1'b1;
      #2;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_ready", {31'b0, req_ready}, 32'd1);
      chk("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("abort_rdata", resp_rdata, 32'd0);
      chk("abort_err", {31'b0, resp_err}, 32'd0);
      chk("abort_dm_read", {31'b0, DM_read}, 32'd0);
      chk("abort_dm_write", {31'b0, DM_write}, 32'd0);
      chk("abort_dm_addr", {16'b0, DM_addr}, 32'd0);
      chk("abort_dm_in", DM_in, 32'd0);
      repeat (3) @(negedge clk);

      // normal service after the abort
`ifdef DM_ACCESS_MISALIGN_CHK_EN
      issue(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 3, 32'h0000005A, 1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0);
`else
      issue(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 3, 32'h00000003, 1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0);
`endif
      wait_idle();
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
